// File: rtl/snakes_pkg.sv
// -----------------------------------------------------------------------------
// snakes_pkg
// Shared type definitions for the snakes game timing/display blocks.
//   mode_t      : stopwatch mode encoding, also decoded by the display and the
//                 game FSM. Codes 5..7 are illegal and recover to IDLE.
//   is_counting : true for the modes in which the live count advances.
// -----------------------------------------------------------------------------
package snakes_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CLEAR   = 3'd1,
        RUNNING = 3'd2,
        PAUSED  = 3'd3,
        LAP     = 3'd4
    } mode_t;

    // The count keeps advancing underneath LAP; only the displayed value freezes.
    function automatic logic is_counting(input mode_t m);
        return (m == RUNNING) || (m == LAP);
    endfunction

endpackage

// File: rtl/button_sync.sv
// -----------------------------------------------------------------------------
// button_sync
// Brings one raw asynchronous push button into the clk domain and turns each
// assertion into a single-cycle press pulse.
// Ports:
//   clk      in  1  system clock, rising edge
//   nRst_i   in  1  asynchronous active-low reset (clears chain and edge flop)
//   btn_i    in  1  raw asynchronous button level, active high
//   press_o  out 1  one-cycle pulse on the rising edge of the synchronised level
// Parameters:
//   SYNC_STAGES  synchroniser depth, >= 2
// The pulse is combinational from the last chain stage and the edge flop, so a
// downstream register acts on it on the (SYNC_STAGES+1)th edge after the first
// edge that samples the button high.
// -----------------------------------------------------------------------------
module button_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic nRst_i,
    input  logic btn_i,
    output logic press_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   prev_q;
    logic                   prev_d;

    assign sync_d[0] = btn_i;

    generate
        for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_chain
            assign sync_d[gi] = sync_q[gi-1];
        end
    endgenerate

    always_comb begin
        prev_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk or negedge nRst_i) begin
        if (!nRst_i) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    // Holding the button keeps both flops high, so only one pulse per assertion.
    assign press_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/lap_stopwatch.sv
// -----------------------------------------------------------------------------
// lap_stopwatch
// Two-button stopwatch with lap snapshot, pause and overflow handling.
// Ports:
//   clk         in  1       system clock, rising edge
//   nRst_i      in  1       asynchronous active-low reset
//   mode_btn_i  in  1       raw mode button (IDLE->CLEAR->RUNNING<->PAUSED, LAP->RUNNING)
//   lap_btn_i   in  1       raw lap button (RUNNING/LAP->LAP with snapshot, PAUSED->IDLE)
//   mode_o      out 3       current mode_t code
//   time_o      out TIME_W  lap snapshot while in LAP, live count otherwise
//   tick_o      out 1       high on each cycle whose edge advances the live count
//   overflow_o  out 1       sticky, set when a tick occurs at the maximum count
// Parameters:
//   TIME_W       count width
//   PRESCALE     clk cycles per tick, >= 1
//   SYNC_STAGES  synchroniser depth per button, >= 2
//   SATURATE     0: count wraps to 0 on overflow, 1: count holds at max
// -----------------------------------------------------------------------------
module lap_stopwatch
    import snakes_pkg::*;
#(
    parameter int TIME_W      = 8,
    parameter int PRESCALE    = 100,
    parameter int SYNC_STAGES = 2,
    parameter int SATURATE    = 0
) (
    input  logic              clk,
    input  logic              nRst_i,
    input  logic              mode_btn_i,
    input  logic              lap_btn_i,
    output logic [2:0]        mode_o,
    output logic [TIME_W-1:0] time_o,
    output logic              tick_o,
    output logic              overflow_o
);

    localparam int                PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]     PRESC_LAST = PW'(PRESCALE - 1);
    localparam logic [TIME_W-1:0] COUNT_MAX  = '1;

    logic mode_press;
    logic lap_press;

    mode_t             mode_q,  mode_d;
    logic [PW-1:0]     presc_q, presc_d;
    logic [TIME_W-1:0] count_q, count_d;
    logic [TIME_W-1:0] lap_q,   lap_d;
    logic              ovf_q,   ovf_d;
    logic              tick;

    button_sync #(.SYNC_STAGES(SYNC_STAGES)) u_mode_sync (
        .clk     (clk),
        .nRst_i  (nRst_i),
        .btn_i   (mode_btn_i),
        .press_o (mode_press)
    );

    button_sync #(.SYNC_STAGES(SYNC_STAGES)) u_lap_sync (
        .clk     (clk),
        .nRst_i  (nRst_i),
        .btn_i   (lap_btn_i),
        .press_o (lap_press)
    );

    // Mode FSM plus the counting datapath. The datapath acts on the mode held
    // before the edge, so the edge that leaves RUNNING still counts normally.
    always_comb begin
        mode_d  = mode_q;
        presc_d = presc_q;
        count_d = count_q;
        lap_d   = lap_q;
        ovf_d   = ovf_q;
        tick    = 1'b0;

        // A mode press always wins over a simultaneous lap press.
        case (mode_q)
            IDLE: begin
                if (mode_press) mode_d = CLEAR;
            end
            CLEAR: begin
                if (mode_press) mode_d = RUNNING;
            end
            RUNNING: begin
                if (mode_press) begin
                    mode_d = PAUSED;
                end else if (lap_press) begin
                    mode_d = LAP;
                    lap_d  = count_q;
                end
            end
            PAUSED: begin
                if (mode_press)     mode_d = RUNNING;
                else if (lap_press) mode_d = IDLE;
            end
            LAP: begin
                if (mode_press) begin
                    mode_d = RUNNING;
                end else if (lap_press) begin
                    lap_d = count_q;
                end
            end
            default: mode_d = IDLE;
        endcase

        if (mode_q == CLEAR) begin
            presc_d = '0;
            count_d = '0;
            ovf_d   = 1'b0;
        end else if (is_counting(mode_q)) begin
            if (presc_q == PRESC_LAST) begin
                tick    = 1'b1;
                presc_d = '0;
                if (count_q == COUNT_MAX) begin
                    ovf_d   = 1'b1;
                    count_d = (SATURATE != 0) ? COUNT_MAX : '0;
                end else begin
                    count_d = count_q + TIME_W'(1);
                end
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge nRst_i) begin
        if (!nRst_i) begin
            mode_q  <= IDLE;
            presc_q <= '0;
            count_q <= '0;
            lap_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            mode_q  <= mode_d;
            presc_q <= presc_d;
            count_q <= count_d;
            lap_q   <= lap_d;
            ovf_q   <= ovf_d;
        end
    end

    assign mode_o     = mode_q;
    assign time_o     = (mode_q == LAP) ? lap_q : count_q;
    assign tick_o     = tick;
    assign overflow_o = ovf_q;

endmodule
